// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 scan-code sequencer for the maze game: turns the controller's byte
// stream into held-key levels and one-cycle move/start/timeout events.
module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [3:0] held,
    output logic       move_pulse,
    output logic [1:0] move_dir,
    output logic       start_pulse,
    output logic       timeout_pulse,
    output logic [7:0] last_code
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic       act_make;
    logic       act_break;
    logic       act_start;
    logic       load_code;
    logic       tmo;
    logic [1:0] act_dir;
    logic [1:0] hidx;

    // {valid, dir} for WASD codes
    function automatic logic [2:0] map_plain(input logic [7:0] code);
        case (code)
            8'h1D:   return 3'b100;
            8'h1B:   return 3'b101;
            8'h1C:   return 3'b110;
            8'h23:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // {valid, dir} for arrow codes (only meaningful after E0)
    function automatic logic [2:0] map_ext(input logic [7:0] code);
        case (code)
            8'h75:   return 3'b100;
            8'h72:   return 3'b101;
            8'h6B:   return 3'b110;
            8'h74:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    logic [2:0] plain_m;
    logic [2:0] ext_m;
    logic       is_e0;
    logic       is_f0;
    logic       is_enter;

    assign plain_m  = map_plain(received_data);
    assign ext_m    = map_ext(received_data);
    assign is_e0    = (received_data == 8'hE0);
    assign is_f0    = (received_data == 8'hF0);
    assign is_enter = (received_data == 8'h5A);
    // held is {up, down, left, right}, so direction d lives at bit 3-d
    assign hidx     = ~act_dir;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        act_make  = 1'b0;
        act_break = 1'b0;
        act_start = 1'b0;
        load_code = 1'b0;
        act_dir   = 2'd0;
        tmo       = 1'b0;
        if (received_data_en) begin
            case (state)
                S_IDLE: begin
                    if (is_e0) begin
                        state_nxt = S_EXT;
                    end else if (is_f0) begin
                        state_nxt = S_BRK;
                    end else if (plain_m[2]) begin
                        act_make  = 1'b1;
                        load_code = 1'b1;
                        act_dir   = plain_m[1:0];
                    end else if (is_enter) begin
                        act_start = 1'b1;
                        load_code = 1'b1;
                    end
                end
                S_EXT: begin
                    if (is_f0) begin
                        state_nxt = S_EXT_BRK;
                    end else if (is_e0) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = S_IDLE;
                        if (ext_m[2]) begin
                            act_make  = 1'b1;
                            load_code = 1'b1;
                            act_dir   = ext_m[1:0];
                        end
                    end
                end
                S_BRK: begin
                    if (is_f0) begin
                        state_nxt = S_BRK;
                    end else if (is_e0) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = S_IDLE;
                        if (plain_m[2]) begin
                            act_break = 1'b1;
                            load_code = 1'b1;
                            act_dir   = plain_m[1:0];
                        end else if (is_enter) begin
                            load_code = 1'b1;
                        end
                    end
                end
                default: begin
                    if (is_f0) begin
                        state_nxt = S_EXT_BRK;
                    end else if (is_e0) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = S_IDLE;
                        if (ext_m[2]) begin
                            act_break = 1'b1;
                            load_code = 1'b1;
                            act_dir   = ext_m[1:0];
                        end
                    end
                end
            endcase
        end else if (state != S_IDLE && cnt == CNT_LIMIT) begin
            state_nxt = S_IDLE;
            tmo       = 1'b1;
        end
    end

    // Idle timer only runs while a prefix is pending and no byte arrives
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (received_data_en || state == S_IDLE || cnt == CNT_LIMIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            held          <= 4'b0000;
            move_pulse    <= 1'b0;
            move_dir      <= 2'd0;
            start_pulse   <= 1'b0;
            timeout_pulse <= 1'b0;
            last_code     <= 8'h00;
        end else begin
            move_pulse    <= 1'b0;
            start_pulse   <= act_start;
            timeout_pulse <= tmo;
            // Typematic repeats of an already-held direction are swallowed here
            if (act_make && !held[hidx]) begin
                held[hidx] <= 1'b1;
                move_pulse <= 1'b1;
                move_dir   <= act_dir;
            end
            if (act_break) begin
                held[hidx] <= 1'b0;
            end
            if (load_code) begin
                last_code <= received_data;
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Randomized bench for ps2_move_decoder against a flag-based behavioural
// model of the PS/2 key protocol, with directed scenarios up front.
module tb_ps2_move_decoder;

    localparam int TO = 8;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [3:0] held;
    logic       move_pulse;
    logic [1:0] move_dir;
    logic       start_pulse;
    logic       timeout_pulse;
    logic [7:0] last_code;

    ps2_move_decoder #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (4)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .held            (held),
        .move_pulse      (move_pulse),
        .move_dir        (move_dir),
        .start_pulse     (start_pulse),
        .timeout_pulse   (timeout_pulse),
        .last_code       (last_code)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: pending prefixes, direction levels indexed 0=up..3=right
    bit       m_ext, m_brk;
    bit       dh[4];
    int       m_idle;
    bit       e_mp, e_sp, e_tp;
    bit [1:0] e_md;
    bit [7:0] e_lc;
    int       n_moves, n_starts, n_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit rn, input bit en, input bit [7:0] d);
        int dir;
        bit enter;
        e_mp = 0; e_sp = 0; e_tp = 0;
        if (!rn) begin
            m_ext = 0; m_brk = 0; m_idle = 0;
            for (int i = 0; i < 4; i++) dh[i] = 0;
            e_md = 0; e_lc = 8'h00;
        end else if (en) begin
            m_idle = 0;
            if (d == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else begin
                dir = -1; enter = 0;
                if (m_ext) begin
                    case (d)
                        8'h75: dir = 0;
                        8'h72: dir = 1;
                        8'h6B: dir = 2;
                        8'h74: dir = 3;
                        default: dir = -1;
                    endcase
                end else begin
                    case (d)
                        8'h1D: dir = 0;
                        8'h1B: dir = 1;
                        8'h1C: dir = 2;
                        8'h23: dir = 3;
                        8'h5A: enter = 1;
                        default: dir = -1;
                    endcase
                end
                if (dir >= 0 || enter) e_lc = d;
                if (dir >= 0) begin
                    if (m_brk) dh[dir] = 0;
                    else if (!dh[dir]) begin
                        dh[dir] = 1; e_mp = 1; e_md = 2'(dir);
                    end
                end
                if (enter && !m_brk) e_sp = 1;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TO) begin
                e_tp = 1; m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit en, input bit [7:0] d);
        resetn = rn; received_data_en = en; received_data = d;
        model(rn, en, d);
        @(posedge CLOCK_50);
        #1;
        check("held", {28'd0, held}, {28'd0, dh[0], dh[1], dh[2], dh[3]});
        check("move_pulse", {31'd0, move_pulse}, {31'd0, e_mp});
        check("move_dir", {30'd0, move_dir}, {30'd0, e_md});
        check("start_pulse", {31'd0, start_pulse}, {31'd0, e_sp});
        check("timeout_pulse", {31'd0, timeout_pulse}, {31'd0, e_tp});
        check("last_code", {24'd0, last_code}, {24'd0, e_lc});
        n_moves  += int'(move_pulse);
        n_starts += int'(start_pulse);
        n_tmo    += int'(timeout_pulse);
        received_data_en = 1'b0;
    endtask

    task automatic send(input bit [7:0] d);
        cyc(1, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 8'h00);
    endtask

    bit [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                           8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h00};

    initial begin
        bit [7:0] b;
        resetn = 1'b0; received_data_en = 1'b0; received_data = 8'h00;
        n_moves = 0; n_starts = 0; n_tmo = 0;
        cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h1D);
        check("reset_held", {28'd0, held}, 32'd0);
        check("reset_last_code", {24'd0, last_code}, 32'd0);

        // Arrow up press
        send(8'hE0); send(8'h75);
        check("up_pulse", {31'd0, move_pulse}, 32'd1);
        check("up_held", {28'd0, held}, 32'b1000);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);

        // Typematic A, then break
        n_moves = 0;
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("rep_held", {28'd0, held}, 32'b0010);
        send(8'hF0); send(8'h1C); idle(1);
        check("rep_moves", n_moves, 32'd1);

        // D and right arrow share a bit
        n_moves = 0;
        send(8'h23); send(8'hE0); send(8'h74);
        send(8'hE0); send(8'hF0); send(8'h74); idle(1);
        check("mix_moves", n_moves, 32'd1);
        check("mix_held", {28'd0, held}, 32'd0);

        // Keypad / extended WASD ignored, Enter twice
        n_moves = 0; n_starts = 0;
        send(8'h75); send(8'hE0); send(8'h1D); send(8'h5A); send(8'h5A); idle(1);
        check("ign_moves", n_moves, 32'd0);
        check("ign_starts", n_starts, 32'd2);

        // Timeout then a stray keypad code
        n_tmo = 0; n_moves = 0;
        send(8'hE0); idle(TO); send(8'h75); idle(1);
        check("tmo_count", n_tmo, 32'd1);
        check("tmo_moves", n_moves, 32'd0);

        // Strobe on the limit cycle wins
        n_tmo = 0;
        send(8'hE0); idle(TO - 1); send(8'h75); idle(1);
        check("bound_tmo", n_tmo, 32'd0);
        check("bound_held", {28'd0, held}, 32'b1000);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Reset in mid-sequence
        n_moves = 0;
        send(8'hE0); cyc(0, 1, 8'h75); send(8'h75); idle(1);
        check("rst_moves", n_moves, 32'd0);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                cyc(0, $urandom_range(0, 1), 8'h1C);
            end else if ($urandom_range(0, 49) == 0) begin
                idle($urandom_range(TO - 2, TO + 2));
            end else if ($urandom_range(0, 9) < 5) begin
                b = pool[$urandom_range(0, 11)];
                if (b == 8'h00) b = 8'($urandom);
                send(b);
            end else begin
                idle(1);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_move_decoder.md
# ps2_move_decoder

Scan-code sequencer that sits directly behind `PS2_Controller` in the maze game input path. It consumes the controller's byte stream (`received_data` / `received_data_en`) and tracks PS/2 set-2 prefix sequences (`E0` extended, `F0` break). It converts the stream into held-key levels and one-cycle move/start events for the maze FSM. It also filters typematic repeats and recovers from truncated sequences with a timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 2500000 — idle cycles, 50 ms at 50 MHz, after a prefix byte before the sequence is abandoned.
- `CNT_W`, default 22 — width of the timeout counter; must hold `TIMEOUT_CYCLES-1`.

Ports:
- `CLOCK_50`, in, 1 — sole clock, rising edge.
- `resetn`, in, 1 — reset, synchronous and active-low.
- `received_data`, in, 8 — byte from `PS2_Controller`.
- `received_data_en`, in, 1 — one-cycle strobe; `received_data` is valid while it is high.
- `held`, out, 4 — registered key levels, `{up, down, left, right}`.
- `move_pulse`, out, 1 — one-cycle strobe on a new direction press.
- `move_dir`, out, 2 — direction code, 0 = up, 1 = down, 2 = left, 3 = right; valid when `move_pulse` is high and holds its value otherwise.
- `start_pulse`, out, 1 — one-cycle strobe on an Enter press.
- `timeout_pulse`, out, 1 — one-cycle strobe when a partial sequence is abandoned.
- `last_code`, out, 8 — last recognised key code without prefixes; intended for HEX display.

## Operation

Key map, PS/2 scan-code set 2:
- Up: extended `E0 75`, or plain `1D` (W).
- Down: extended `E0 72`, or plain `1B` (S).
- Left: extended `E0 6B`, or plain `1C` (A).
- Right: extended `E0 74`, or plain `23` (D).
- Enter (start): plain `5A`.
- `75`/`72`/`6B`/`74` without an `E0` prefix are keypad codes and are ignored.
- WASD and Enter codes preceded by `E0` are ignored.
- A press (make) is the code alone; a release (break) is `F0` followed by the code.

State machine, with transitions evaluated only in cycles where `received_data_en` = 1:
- IDLE:
  - `E0` → EXT; `F0` → BRK.
  - A mapped code → make action, stay in IDLE.
  - Any other byte → IDLE.
- EXT:
  - `F0` → EXT_BRK; `E0` → EXT.
  - A mapped extended code → make action → IDLE.
  - Any other byte → IDLE.
- BRK:
  - A mapped plain code → break action → IDLE.
  - `F0` → BRK; `E0` → EXT.
  - Any other byte → IDLE.
- EXT_BRK:
  - A mapped extended code → break action → IDLE.
  - `F0` → EXT_BRK; `E0` → EXT.
  - Any other byte → IDLE.

Make action for direction d:
- If `held[d]` = 0: set `held[d]`, pulse `move_pulse`, load `move_dir` = d.
- If `held[d]` = 1 (typematic repeat): no pulse and no change.
- Arrow and WASD for the same direction share one `held` bit.

Other actions:
- Enter make: pulse `start_pulse` on every make. Enter is not tracked in `held` and repeats are not filtered.
- Break action: clear `held[d]`. No pulse. A break for a key not held is harmless.
- `last_code` loads the code byte on every make or break action for a mapped key.

Timeout:
- The counter clears on every `received_data_en` and whenever the state is IDLE.
- Outside IDLE, the counter increments each cycle without a strobe.
- When the counter reaches `TIMEOUT_CYCLES-1`, the next edge forces IDLE and pulses `timeout_pulse`. `held` is unchanged.
- If a strobe arrives in the same cycle the count reaches its limit, the strobe wins: the byte is processed normally and there is no timeout.

## Timing

- All outputs are registered.
- An action happens on the edge at the end of the strobe cycle; its outputs are visible in the following cycle.
- `move_pulse`, `start_pulse` and `timeout_pulse` are high for exactly one cycle and are never asserted in the same cycle as one another.
- Back-to-back strobes on consecutive cycles must be accepted, one byte per cycle.
- Reset values, with `resetn` = 0 sampled at an edge:
  - `held` = 0, `move_pulse` = 0, `start_pulse` = 0, `timeout_pulse` = 0.
  - `move_dir` = 0, `last_code` = 8'h00.
  - State = IDLE, counter = 0.
- Reset during a partial sequence discards the sequence.
- A strobe in a reset cycle is ignored.

## Test plan

- Reset, then `E0`, `75` on consecutive strobes:
  - One cycle later: `move_pulse` = 1, `move_dir` = 0, `held` = 4'b1000, `last_code` = 8'h75.
- Typematic repeat: send `1C` three times, then `F0 1C`:
  - Exactly one `move_pulse` with `move_dir` = 2; `held` = 4'b0010 until the break, then 4'b0000.
- Mixed keys: `23`, then `E0 74`, then `E0 F0 74`:
  - One pulse only, with `move_dir` = 3; `held[0]` clears after the extended break.
- Ignored and start codes: `75` alone, then `E0 1D`, then `5A`, `5A`:
  - No `move_pulse`; `held` = 0; two `start_pulse`s.
- Timeout with `TIMEOUT_CYCLES` = 8: send `E0`, wait 8 cycles, then send `75`:
  - `timeout_pulse` 8 cycles after the `E0` strobe.
  - The trailing `75` is ignored as a keypad code, so no `move_pulse`.
- Strobe on the boundary: a strobe landing exactly on the 8th cycle processes normally with no `timeout_pulse`.
- Reset mid-sequence: `E0`, assert `resetn` = 0 for 1 cycle, then `75`:
  - No `move_pulse`; all outputs at reset values.
